// File: rtl/wb2axi_read.sv
// Read-only Wishbone slave to AXI4 single-beat read master bridge.
// One read per qualified request; the armed flag blocks repeats while the request stays high.
module wb2axi_read #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic                  wb_cyc,
    input  logic                  i_cnt_done,
    output logic [DATA_WIDTH-1:0] wb_rdt,
    output logic                  wb_ack,
    output logic [ID_WIDTH-1:0]   M_AXI_arid,
    output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
    output logic [7:0]            M_AXI_arlen,
    output logic [2:0]            M_AXI_arsize,
    output logic [1:0]            M_AXI_arburst,
    output logic [1:0]            M_AXI_arlock,
    output logic [3:0]            M_AXI_arcache,
    output logic [2:0]            M_AXI_arprot,
    output logic [3:0]            M_AXI_arqos,
    output logic [3:0]            M_AXI_arregion,
    output logic                  M_AXI_arvalid,
    input  logic                  M_AXI_arready,
    input  logic [ID_WIDTH-1:0]   M_AXI_rid,
    input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
    input  logic [1:0]            M_AXI_rresp,
    input  logic                  M_AXI_rlast,
    input  logic                  M_AXI_rvalid,
    output logic                  M_AXI_rready
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R
    } state_e;

    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

    state_e                state_q;
    logic                  armed_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [DATA_WIDTH-1:0] rdt_q;
    logic                  ack_q;
    logic                  unused_ok;

    // Response ID and status are deliberately not inspected.
    assign unused_ok = ^{M_AXI_rid, M_AXI_rresp};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdt_q     <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            // Re-arm only once the master has let go of the request.
            if (!wb_cyc || !i_cnt_done) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (wb_cyc && i_cnt_done && armed_q) begin
                        araddr_q  <= wb_adr;
                        arvalid_q <= 1'b1;
                        armed_q   <= 1'b0;
                        state_q   <= AR;
                    end
                end
                AR: begin
                    if (M_AXI_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (M_AXI_rvalid && M_AXI_rlast) begin
                        rdt_q    <= M_AXI_rdata;
                        ack_q    <= 1'b1;
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_rdt         = rdt_q;
    assign wb_ack         = ack_q;
    assign M_AXI_arid     = '0;
    assign M_AXI_araddr   = araddr_q;
    assign M_AXI_arlen    = '0;
    assign M_AXI_arsize   = ARSIZE;
    assign M_AXI_arburst  = 2'b01;
    assign M_AXI_arlock   = '0;
    assign M_AXI_arcache  = 4'b0011;
    assign M_AXI_arprot   = '0;
    assign M_AXI_arqos    = '0;
    assign M_AXI_arregion = '0;
    assign M_AXI_arvalid  = arvalid_q;
    assign M_AXI_rready   = rready_q;

endmodule

// File: tb/tb_wb2axi_read.sv
// Directed bench for wb2axi_read: request qualification, handshakes, re-arm and async reset.
module tb_wb2axi_read;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] wb_adr = '0;
    logic        wb_cyc = 1'b0;
    logic        i_cnt_done = 1'b0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic [3:0]  M_AXI_arid;
    logic [31:0] M_AXI_araddr;
    logic [7:0]  M_AXI_arlen;
    logic [2:0]  M_AXI_arsize;
    logic [1:0]  M_AXI_arburst;
    logic [1:0]  M_AXI_arlock;
    logic [3:0]  M_AXI_arcache;
    logic [2:0]  M_AXI_arprot;
    logic [3:0]  M_AXI_arqos;
    logic [3:0]  M_AXI_arregion;
    logic        M_AXI_arvalid;
    logic        M_AXI_arready = 1'b0;
    logic [3:0]  M_AXI_rid = '0;
    logic [31:0] M_AXI_rdata = '0;
    logic [1:0]  M_AXI_rresp = '0;
    logic        M_AXI_rlast = 1'b0;
    logic        M_AXI_rvalid = 1'b0;
    logic        M_AXI_rready;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 ACLK = ~ACLK;

    wb2axi_read #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .wb_adr        (wb_adr),
        .wb_cyc        (wb_cyc),
        .i_cnt_done    (i_cnt_done),
        .wb_rdt        (wb_rdt),
        .wb_ack        (wb_ack),
        .M_AXI_arid    (M_AXI_arid),
        .M_AXI_araddr  (M_AXI_araddr),
        .M_AXI_arlen   (M_AXI_arlen),
        .M_AXI_arsize  (M_AXI_arsize),
        .M_AXI_arburst (M_AXI_arburst),
        .M_AXI_arlock  (M_AXI_arlock),
        .M_AXI_arcache (M_AXI_arcache),
        .M_AXI_arprot  (M_AXI_arprot),
        .M_AXI_arqos   (M_AXI_arqos),
        .M_AXI_arregion(M_AXI_arregion),
        .M_AXI_arvalid (M_AXI_arvalid),
        .M_AXI_arready (M_AXI_arready),
        .M_AXI_rid     (M_AXI_rid),
        .M_AXI_rdata   (M_AXI_rdata),
        .M_AXI_rresp   (M_AXI_rresp),
        .M_AXI_rlast   (M_AXI_rlast),
        .M_AXI_rvalid  (M_AXI_rvalid),
        .M_AXI_rready  (M_AXI_rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Issues one read from IDLE. keep_req holds cyc/cnt_done high through the read.
    task automatic do_read(input logic [31:0] adr, input logic [31:0] data,
                           input int unsigned ar_wait, input bit junk_beat, input bit keep_req);
        wb_adr = adr;
        wb_cyc = 1'b1;
        i_cnt_done = 1'b1;
        tick();
        check_eq("arvalid_set", 64'(M_AXI_arvalid), 64'd1);
        check_eq("araddr", 64'(M_AXI_araddr), 64'(adr));
        if (!keep_req) begin
            wb_cyc = 1'b0;
            i_cnt_done = 1'b0;
        end
        wb_adr = 32'hDEAD_BEEF;
        for (int unsigned i = 0; i < ar_wait; i++) begin
            tick();
            check_eq("arvalid_hold", 64'(M_AXI_arvalid), 64'd1);
            check_eq("araddr_hold", 64'(M_AXI_araddr), 64'(adr));
        end
        M_AXI_arready = 1'b1;
        tick();
        M_AXI_arready = 1'b0;
        check_eq("arvalid_clr", 64'(M_AXI_arvalid), 64'd0);
        check_eq("rready_set", 64'(M_AXI_rready), 64'd1);
        if (junk_beat) begin
            M_AXI_rvalid = 1'b1;
            M_AXI_rlast = 1'b0;
            M_AXI_rdata = 32'hBAD0_BAD0;
            tick();
            check_eq("junk_noack", 64'(wb_ack), 64'd0);
            check_eq("junk_rready", 64'(M_AXI_rready), 64'd1);
        end
        M_AXI_rvalid = 1'b1;
        M_AXI_rlast = 1'b1;
        M_AXI_rdata = data;
        M_AXI_rresp = 2'b10;
        tick();
        M_AXI_rvalid = 1'b0;
        M_AXI_rlast = 1'b0;
        M_AXI_rresp = 2'b00;
        M_AXI_rdata = 32'h5555_AAAA;
        check_eq("ack_pulse", 64'(wb_ack), 64'd1);
        check_eq("rdt", 64'(wb_rdt), 64'(data));
        check_eq("rready_clr", 64'(M_AXI_rready), 64'd0);
        tick();
        check_eq("ack_low", 64'(wb_ack), 64'd0);
        check_eq("rdt_hold", 64'(wb_rdt), 64'(data));
    endtask

    initial begin
        #12;
        check_eq("rst_arvalid", 64'(M_AXI_arvalid), 64'd0);
        check_eq("rst_rready", 64'(M_AXI_rready), 64'd0);
        check_eq("rst_ack", 64'(wb_ack), 64'd0);
        check_eq("rst_araddr", 64'(M_AXI_araddr), 64'd0);
        check_eq("rst_rdt", 64'(wb_rdt), 64'd0);
        check_eq("arsize", 64'(M_AXI_arsize), 64'd2);
        check_eq("arburst", 64'(M_AXI_arburst), 64'd1);
        check_eq("arcache", 64'(M_AXI_arcache), 64'd3);
        check_eq("arlen", 64'(M_AXI_arlen), 64'd0);
        check_eq("arid", 64'(M_AXI_arid), 64'd0);
        ARESETN = 1'b1;
        tick();

        // cyc without cnt_done never starts a read
        wb_cyc = 1'b1;
        wb_adr = 32'h0000_0040;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("nocnt_arvalid", 64'(M_AXI_arvalid), 64'd0);
        end
        wb_cyc = 1'b0;
        tick();

        do_read(32'h4, 32'h1234_5678, 2, 1'b1, 1'b0);

        wb_cyc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("wait_arvalid", 64'(M_AXI_arvalid), 64'd0);
        end
        do_read(32'h8, 32'hABCD_EF00, 0, 1'b0, 1'b0);

        for (int unsigned i = 0; i < 5; i++) begin
            do_read(32'(4 * i), 32'(i), 0, 1'b0, 1'b0);
        end

        // request held high after ack must not start a second read
        do_read(32'h100, 32'hCAFE_F00D, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("noreissue", 64'(M_AXI_arvalid), 64'd0);
        end
        i_cnt_done = 1'b0;
        tick();
        check_eq("rearm_idle", 64'(M_AXI_arvalid), 64'd0);
        do_read(32'h104, 32'h0BAD_CAFE, 1, 1'b0, 1'b0);

        // async reset while waiting in AR
        wb_adr = 32'h20;
        wb_cyc = 1'b1;
        i_cnt_done = 1'b1;
        tick();
        check_eq("pre_rst_arvalid", 64'(M_AXI_arvalid), 64'd1);
        wb_cyc = 1'b0;
        i_cnt_done = 1'b0;
        #2;
        ARESETN = 1'b0;
        #1;
        check_eq("arst_arvalid", 64'(M_AXI_arvalid), 64'd0);
        check_eq("arst_araddr", 64'(M_AXI_araddr), 64'd0);
        check_eq("arst_rdt", 64'(wb_rdt), 64'd0);
        check_eq("arst_rready", 64'(M_AXI_rready), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        M_AXI_arready = 1'b1;
        tick();
        check_eq("post_rst_idle", 64'(M_AXI_arvalid), 64'd0);
        check_eq("post_rst_rready", 64'(M_AXI_rready), 64'd0);
        M_AXI_arready = 1'b0;
        do_read(32'h24, 32'h7777_1111, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
